// File: rtl/core_defs_pkg.sv
// Shared RV32I core definitions: data-memory access encodings and the LSU state type.
package core_defs;

  localparam int unsigned CORE_XLEN = 32;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;
  localparam logic [2:0] MEM_SB  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store replication,
// load shift/extension and access-fault classification.
module lsu_align
  import core_defs::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic            memWR,
  input  logic [2:0]      memCtrl,
  input  logic [1:0]      addrLo,
  input  logic [XLEN-1:0] storeData,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] loadExt,
  output logic            misaligned,
  output logic            illegal
);

  logic            isByte;
  logic            isHalf;
  logic            isWord;
  logic [XLEN-1:0] shifted;

  always_comb begin
    isByte = 1'b0;
    isHalf = 1'b0;
    isWord = 1'b0;
    case (memCtrl)
      MEM_LB, MEM_LBU, MEM_SB: isByte = 1'b1;
      MEM_LH, MEM_LHU, MEM_SH: isHalf = 1'b1;
      default:                 isWord = 1'b1;
    endcase

    illegal    = !memWR && (memCtrl inside {MEM_SB, MEM_SH, MEM_SW});
    misaligned = !illegal && ((isHalf && addrLo[0]) || (isWord && (addrLo != 2'b00)));

    be    = 4'b1111;
    wdata = storeData;
    if (isByte) begin
      be    = 4'b0001 << addrLo;
      wdata = {(XLEN/8){storeData[7:0]}};
    end else if (isHalf) begin
      be    = 4'b0011 << {addrLo[1], 1'b0};
      wdata = {(XLEN/16){storeData[15:0]}};
    end

    shifted = rdata >> {addrLo, 3'b000};
    case (memCtrl)
      MEM_LB:  loadExt = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MEM_LH:  loadExt = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MEM_LW:  loadExt = shifted;
      MEM_LBU: loadExt = {{(XLEN-8){1'b0}}, shifted[7:0]};
      MEM_LHU: loadExt = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: loadExt = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: request/grant/response data-memory FSM with
// registered bus outputs, pipeline stall and extended load return.
module load_store_unit
  import core_defs::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic            memWR,
  input  logic [2:0]      memCtrl,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned,
  output logic            illegal,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic [XLEN-1:0] dmemAddr,
  output logic [XLEN-1:0] dmemWdata,
  output logic [3:0]      dmemBe,
  input  logic            dmemGnt,
  input  logic            dmemRvalid,
  input  logic [XLEN-1:0] dmemRdata
);

  lsu_state_e      state_q, state_d;
  logic            wr_q, wr_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [1:0]      alo_q, alo_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] load_q, load_d;
  logic            mis_q, mis_d;
  logic            ill_q, ill_d;

  logic            alWr;
  logic [2:0]      alCtrl;
  logic [1:0]      alAddrLo;
  logic [3:0]      alBe;
  logic [XLEN-1:0] alWdata;
  logic [XLEN-1:0] alLoad;
  logic            alMis;
  logic            alIll;

  // One aligner serves both phases: live inputs while IDLE, latched access in WAIT.
  always_comb begin
    if (state_q == LSU_IDLE) begin
      alWr     = memWR;
      alCtrl   = memCtrl;
      alAddrLo = addr[1:0];
    end else begin
      alWr     = wr_q;
      alCtrl   = ctrl_q;
      alAddrLo = alo_q;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .memWR      (alWr),
    .memCtrl    (alCtrl),
    .addrLo     (alAddrLo),
    .storeData  (storeData),
    .rdata      (dmemRdata),
    .be         (alBe),
    .wdata      (alWdata),
    .loadExt    (alLoad),
    .misaligned (alMis),
    .illegal    (alIll)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    alo_d   = alo_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    load_d  = load_q;
    mis_d   = mis_q;
    ill_d   = ill_q;

    case (state_q)
      LSU_IDLE: begin
        if (start) begin
          wr_d   = memWR;
          ctrl_d = memCtrl;
          alo_d  = addr[1:0];
          load_d = '0;
          mis_d  = alMis;
          ill_d  = alIll;
          if (alIll || alMis) begin
            state_d = LSU_DONE;
          end else begin
            state_d = LSU_REQ;
            req_d   = 1'b1;
            we_d    = memWR;
            addr_d  = {addr[XLEN-1:2], 2'b00};
            be_d    = alBe;
            wdata_d = alWdata;
          end
        end
      end
      LSU_REQ: begin
        if (dmemGnt) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = wr_q ? LSU_DONE : LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (dmemRvalid) begin
          load_d  = alLoad;
          state_d = LSU_DONE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= LSU_IDLE;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      alo_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      alo_q   <= alo_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  assign busy       = ((state_q == LSU_IDLE) && start) || (state_q == LSU_REQ) || (state_q == LSU_WAIT);
  assign done       = (state_q == LSU_DONE);
  assign loadData   = load_q;
  assign misaligned = mis_q;
  assign illegal    = ill_q;
  assign dmemReq    = req_q;
  assign dmemWe     = we_q;
  assign dmemAddr   = addr_q;
  assign dmemWdata  = wdata_q;
  assign dmemBe     = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        memWR;
  logic [2:0]  memCtrl;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic [31:0] loadData;
  logic        misaligned;
  logic        illegal;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [3:0]  dmemBe;
  logic        dmemGnt;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .start      (start),
    .memWR      (memWR),
    .memCtrl    (memCtrl),
    .addr       (addr),
    .storeData  (storeData),
    .busy       (busy),
    .done       (done),
    .loadData   (loadData),
    .misaligned (misaligned),
    .illegal    (illegal),
    .dmemReq    (dmemReq),
    .dmemWe     (dmemWe),
    .dmemAddr   (dmemAddr),
    .dmemWdata  (dmemWdata),
    .dmemBe     (dmemBe),
    .dmemGnt    (dmemGnt),
    .dmemRvalid (dmemRvalid),
    .dmemRdata  (dmemRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes drives every rule.
  task automatic ref_model(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           output logic ill, output logic mis, output logic [3:0] be,
                           output logic [31:0] wd, output logic [31:0] ld);
    int unsigned size;
    int unsigned off;
    logic [31:0] mask;
    logic [31:0] v;
    case (ctrl)
      3'd0, 3'd3, 3'd5: size = 1;
      3'd1, 3'd4, 3'd6: size = 2;
      default:          size = 4;
    endcase
    off  = a % 4;
    ill  = !wr && (ctrl >= 3'd5);
    mis  = !ill && ((a % size) != 0);
    be   = 4'(((1 << size) - 1) << off);
    if (size == 1)      wd = {24'h0, sd[7:0]} * 32'h01010101;
    else if (size == 2) wd = {16'h0, sd[15:0]} * 32'h00010001;
    else                wd = sd;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v    = (rd >> (8 * off)) & mask;
    if (((ctrl == 3'd0) || (ctrl == 3'd1)) && v[8*size-1]) v = v | ~mask;
    ld   = (wr || ill || mis) ? 32'h0 : v;
  endtask

  task automatic idle(input int unsigned k);
    repeat (k) begin
      tick;
      start      = 1'b0;
      dmemGnt    = 1'b0;
      dmemRvalid = 1'b0;
    end
  endtask

  task automatic txn(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd,
                     input int unsigned gd, input int unsigned rdl);
    logic        eIll, eMis, fault, expReq, granted, gotDone;
    logic [3:0]  eBe;
    logic [31:0] eWd, eLd;
    int unsigned lat, n, gntAt;
    ref_model(wr, ctrl, a, sd, rd, eIll, eMis, eBe, eWd, eLd);
    fault = eIll || eMis;
    lat   = fault ? 1 : (wr ? 2 + gd : 2 + gd + rdl);

    tick;
    start      = 1'b1;
    memWR      = wr;
    memCtrl    = ctrl;
    addr       = a;
    storeData  = sd;
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b0;
    dmemRdata  = $urandom;
    #1;
    chk("busy_at_start", busy, 1);
    chk("done_low_at_start", done, 0);

    granted = 1'b0;
    gotDone = 1'b0;
    gntAt   = 0;
    n       = 0;
    while (!gotDone && n < 60) begin
      tick;
      n++;
      start     = 1'($urandom_range(0, 1));
      memWR     = 1'($urandom_range(0, 1));
      memCtrl   = 3'($urandom_range(0, 7));
      addr      = $urandom;
      storeData = $urandom;
      if (!fault && !granted) begin
        dmemGnt    = (n - 1 == gd);
        dmemRvalid = 1'($urandom_range(0, 1));
        dmemRdata  = $urandom;
      end else if (!fault && !wr && n <= gntAt + rdl) begin
        dmemGnt    = 1'($urandom_range(0, 1));
        dmemRvalid = (n == gntAt + rdl);
        dmemRdata  = (n == gntAt + rdl) ? rd : $urandom;
      end else begin
        dmemGnt    = 1'($urandom_range(0, 1));
        dmemRvalid = 1'($urandom_range(0, 1));
        dmemRdata  = $urandom;
      end
      #1;
      expReq = !fault && !granted;
      chk("dmemReq", dmemReq, expReq);
      if (expReq) begin
        chk("dmemAddr", dmemAddr, a & 32'hFFFF_FFFC);
        chk("dmemBe", dmemBe, eBe);
        chk("dmemWe", dmemWe, wr);
        if (wr) chk("dmemWdata", dmemWdata, eWd);
      end
      if (done) begin
        gotDone = 1'b1;
        chk("latency", n, lat);
        chk("loadData", loadData, eLd);
        chk("misaligned", misaligned, eMis);
        chk("illegal", illegal, eIll);
        chk("busy_in_done", busy, 0);
      end else begin
        chk("busy_while_pending", busy, 1);
      end
      if (expReq && dmemGnt) begin
        granted = 1'b1;
        gntAt   = n;
      end
    end
    if (!gotDone) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dmemReq"}, dmemReq, 0);
    chk({tag, "_dmemWe"}, dmemWe, 0);
    chk({tag, "_dmemAddr"}, dmemAddr, 0);
    chk({tag, "_dmemWdata"}, dmemWdata, 0);
    chk({tag, "_dmemBe"}, dmemBe, 0);
    chk({tag, "_loadData"}, loadData, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_misaligned"}, misaligned, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] a;

    rstN       = 1'b0;
    start      = 1'b0;
    memWR      = 1'b0;
    memCtrl    = 3'd0;
    addr       = '0;
    storeData  = '0;
    dmemGnt    = 1'b0;
    dmemRvalid = 1'b0;
    dmemRdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstN = 1'b1;

    // Directed cases
    txn(1'b1, 3'b111, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 1);
    txn(1'b0, 3'b011, 32'h103, 32'h0, 32'h80123456, 0, 1);
    txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001ABCD, 0, 1);
    txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h8001ABCD, 0, 1);
    txn(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3, 2);
    txn(1'b0, 3'b110, 32'h104, 32'h0, 32'h12345678, 0, 1);
    txn(1'b1, 3'b101, 32'h002, 32'h0000005A, 32'h0, 0, 1);
    txn(1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 0, 1);

    // Reset while a load sits in WAIT; the late response must be dropped
    tick;
    start     = 1'b1;
    memWR     = 1'b0;
    memCtrl   = 3'b010;
    addr      = 32'h200;
    storeData = '0;
    tick;
    start   = 1'b0;
    dmemGnt = 1'b1;
    tick;
    dmemGnt = 1'b0;
    #1;
    chk("wait_busy", busy, 1);
    chk("wait_req_dropped", dmemReq, 0);
    rstN = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    tick;
    rstN       = 1'b1;
    dmemRvalid = 1'b1;
    dmemRdata  = 32'h13572468;
    #1;
    chk("post_reset_done", done, 0);
    tick;
    dmemRvalid = 1'b0;
    #1;
    chk("post_reset_done2", done, 0);
    chk("post_reset_loadData", loadData, 0);
    txn(1'b0, 3'b100, 32'h206, 32'h0, 32'h9ABC0000, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      wr   = 1'($urandom_range(0, 1));
      ctrl = wr ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 7));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) << 1);
      txn(wr, ctrl, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the RV32I core. It consumes the decoder's `memWR`/`memCtrl` and the execute stage's address and store data, then runs a request/grant/response transaction on the data-memory port. It returns sign- or zero-extended load data to writeback and stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rstN  in  1  reset, asynchronous and active-low.
- start  in  1  memory instruction present this cycle; sampled only in IDLE.
- memWR  in  1  1 = store, 0 = load.
- memCtrl  in  3  access type:
  - 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
  - 101 SB, 110 SH, 111 SW; these are valid only with memWR=1.
- addr  in  XLEN  effective byte address (ALU result).
- storeData  in  XLEN  rs2 value.
- busy  out  1  pipeline stall request.
- done  out  1  one-cycle completion pulse.
- loadData  out  XLEN  extended load result; valid while done=1.
- misaligned  out  1  alignment fault; valid while done=1.
- illegal  out  1  illegal access type; valid while done=1.
- dmemReq  out  1  bus request.
- dmemWe  out  1  write enable.
- dmemAddr  out  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}.
- dmemWdata  out  XLEN  lane-replicated store data.
- dmemBe  out  4  byte enables.
- dmemGnt  in  1  request accepted.
- dmemRvalid  in  1  read data valid.
- dmemRdata  in  XLEN  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start=1, latch memWR, memCtrl, addr and storeData.
  - Illegal (memWR=0 with memCtrl ∈ {101,110,111}) -> DONE with illegal=1.
  - Else misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0) -> DONE with misaligned=1.
  - Else -> REQ.
  - Illegal and misaligned accesses issue no bus request.
- REQ:
  - dmemReq=1; dmemAddr, dmemWe, dmemBe and dmemWdata stay stable until grant.
  - On dmemGnt, a store -> DONE and a load -> WAIT.
- WAIT: capture dmemRdata on dmemRvalid -> DONE. dmemRvalid in the grant cycle is not accepted; responses arrive ≥1 cycle after grant.
- DONE: done=1 for one cycle, then -> IDLE. Flags and loadData are held in registers.
- Byte enables:
  - Byte access: 4'b0001<<addr[1:0].
  - Halfword access: 4'b0011<<{addr[1],1'b0}.
  - Word access: 4'b1111.
  - Loads drive the same enables.
- Store data: SB {4{storeData[7:0]}}, SH {2{storeData[15:0]}}, SW storeData.
- Load data:
  - Shift dmemRdata right by addr[1:0]*8.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - loadData=0 for stores, faults and illegal accesses.
- busy = start in IDLE (combinational), or state ∈ {REQ, WAIT}. busy=0 in DONE so the pipeline advances on the completion cycle.
- start is ignored outside IDLE. dmemRvalid and dmemGnt are ignored outside WAIT and REQ respectively.

## Timing
- Reset values: state IDLE; dmemReq, dmemWe, done, misaligned, illegal all 0; dmemBe, dmemAddr, dmemWdata and loadData all 0.
- Bus outputs are registered; none depends combinationally on dmemGnt or dmemRvalid.
- Store with immediate grant: start@T, REQ@T+1 (grant), done@T+2.
- Load with immediate grant and rvalid one cycle later: start@T, REQ@T+1, WAIT@T+2 (rvalid), done@T+3.
- Fault or illegal access: start@T, done@T+1, with no dmemReq.
- Each cycle without grant or rvalid adds one cycle of latency; there is no timeout.
- Reset mid-operation: immediate return to IDLE with outputs at reset values. A dmemRvalid arriving afterwards is ignored.
- Back-to-back accesses: the next start is accepted in the IDLE cycle after DONE. Minimum period is 3 cycles for stores and 4 for loads.

## Structure
- Shared package `core_defs`:
  - memCtrl encodings MEM_LB … MEM_SW.
  - The LSU state encoding (2 bits).
  - XLEN default.
- Sub-module `lsu_align` (combinational): computes byte enables, store replication, load shift and extension, and the misaligned/illegal flags. The FSM and registers live in `load_store_unit`.

## Test plan
- SW addr=0x100, data=0xDEADBEEF, gnt same cycle -> dmemBe=1111, dmemWdata=0xDEADBEEF, done at T+2, busy high at T and T+1.
- LB addr=0x103, rdata=0x80123456 -> dmemBe=1000, dmemAddr=0x100, loadData=0xFFFFFF80; LBU with the same stimulus -> 0x00000080.
- LH addr=0x102, rdata=0x8001ABCD -> loadData=0xFFFF8001. LH addr=0x101 -> misaligned=1 at T+1 with no dmemReq.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after grant -> request stable throughout, done at T+7, loadData equals rdata.
- memWR=0, memCtrl=110 -> illegal=1, loadData=0, no bus activity. SB addr=0x2, data=0x5A -> dmemBe=0100, dmemWdata=0x5A5A5A5A.
- rstN low during WAIT, then rvalid pulses -> outputs return to reset values immediately, no done pulse, next start served normally.
